// File: rtl/latch_rr_arbiter.sv
// Round-robin owner selection for a shared transparent-latch stage (enable + data).
// Latency: a request seen in IDLE or in the last RELEASE cycle is granted on the next cycle.
// Backpressure: none is applied; a requester holds req until it sees done, or drops req to abort.
module latch_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int HOLD  = 4,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    data_in,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     lat_en,
  output logic [WIDTH-1:0]         lat_data,
  output logic [NREQ-1:0]          done,
  output logic                     busy
);

  localparam int IW   = $clog2(NREQ);
  localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic             lat_en_q, lat_en_d;
  logic [WIDTH-1:0] lat_data_q, lat_data_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q, busy_d;

  logic             arb_vld;
  logic [IW-1:0]    arb_idx;

  // Round-robin search: first asserted request after the last winner, wrapping around.
  always_comb begin
    int j;
    j       = 0;
    arb_vld = 1'b0;
    arb_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(ptr_q) + i) % NREQ;
      if (!arb_vld && req[j]) begin
        arb_vld = 1'b1;
        arb_idx = IW'(j);
      end
    end
  end

  // Next-state and registered-output computation for IDLE / GRANT / RELEASE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    gnt_d      = '0;
    lat_en_d   = 1'b0;
    lat_data_d = '0;
    done_d     = '0;

    case (state_q)
      S_GRANT: begin
        if (!req[owner_q]) begin
          // Owner abandoned the window: close the latch without a done pulse.
          state_d = S_RELEASE;
          cnt_d   = CW'(GAP - 1);
        end else if (cnt_q == '0) begin
          state_d         = S_RELEASE;
          cnt_d           = CW'(GAP - 1);
          done_d[owner_q] = 1'b1;
        end else begin
          cnt_d      = cnt_q - CW'(1);
          gnt_d      = gnt_q;
          lat_en_d   = 1'b1;
          lat_data_d = data_in[owner_q*WIDTH +: WIDTH];
        end
      end
      S_RELEASE, S_IDLE: begin
        if (state_q == S_RELEASE && cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (arb_vld) begin
          state_d    = S_GRANT;
          cnt_d      = CW'(HOLD - 1);
          ptr_d      = arb_idx;
          owner_d    = arb_idx;
          gnt_d      = ONE_HOT0 << arb_idx;
          lat_en_d   = 1'b1;
          lat_data_d = data_in[arb_idx*WIDTH +: WIDTH];
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset parks the pointer so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ptr_q      <= IW'(NREQ - 1);
      owner_q    <= '0;
      gnt_q      <= '0;
      lat_en_q   <= 1'b0;
      lat_data_q <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      lat_en_q   <= lat_en_d;
      lat_data_q <= lat_data_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt      = gnt_q;
  assign owner    = owner_q;
  assign lat_en   = lat_en_q;
  assign lat_data = lat_data_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_latch_rr_arbiter.sv
// Directed bench for latch_rr_arbiter with NREQ=4, WIDTH=8, HOLD=3, GAP=1.
module tb_latch_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [WIDTH-1:0]        d [NREQ];
  logic [NREQ*WIDTH-1:0]   data_in;
  logic [NREQ-1:0]         gnt;
  logic [1:0]              owner;
  logic                    lat_en;
  logic [WIDTH-1:0]        lat_data;
  logic [NREQ-1:0]         done;
  logic                    busy;

  int total = 0;
  int bad   = 0;

  assign data_in = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  latch_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(3), .GAP(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .gnt      (gnt),
    .owner    (owner),
    .lat_en   (lat_en),
    .lat_data (lat_data),
    .done     (done),
    .busy     (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full check of the observable outputs for one cycle.
  task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic e_en,
                         input logic [7:0] e_dat, input logic [3:0] e_done, input logic e_busy);
    chk({tag, ".gnt"},      32'(gnt),      32'(e_gnt));
    chk({tag, ".lat_en"},   32'(lat_en),   32'(e_en));
    chk({tag, ".lat_data"}, 32'(lat_data), 32'(e_dat));
    chk({tag, ".done"},     32'(done),     32'(e_done));
    chk({tag, ".busy"},     32'(busy),     32'(e_busy));
  endtask

  // One ownership window: HOLD high cycles for requester k, then the gap cycle.
  task automatic window(input string tag, input int k, input logic [7:0] dat, input bit exp_done);
    logic [3:0] oh;
    oh = 4'b0001 << k;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_all($sformatf("%s.g%0d", tag, c), oh, 1'b1, dat, 4'b0000, 1'b1);
      chk({tag, ".owner"}, 32'(owner), 32'(k));
    end
    step();
    chk_all({tag, ".rel"}, 4'b0000, 1'b0, 8'h00, exp_done ? oh : 4'b0000, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    d[0] = 8'h10; d[1] = 8'h21; d[2] = 8'hA5; d[3] = 8'h33;

    // Reset held with every request active: everything stays quiet.
    step(); step(); step();
    chk_all("reset", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
    chk("reset.owner", 32'(owner), 32'd0);

    // All four requesting: owners rotate 0,1,2,3,0 with one gap cycle between.
    rst = 1'b0;
    window("rr0", 0, 8'h10, 1'b1);
    window("rr1", 1, 8'h21, 1'b1);
    window("rr2", 2, 8'hA5, 1'b1);
    window("rr3", 3, 8'h33, 1'b1);
    window("rr0b", 0, 8'h10, 1'b1);

    // Requests gone during the final gap cycle: fall back to IDLE, owner kept.
    req = 4'b0000;
    step();
    chk_all("idle", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
    chk("idle.owner", 32'(owner), 32'd0);

    // Single request from requester 2, then immediate re-grant after one gap.
    req = 4'b0100;
    window("single", 2, 8'hA5, 1'b1);
    step();
    chk_all("regrant", 4'b0100, 1'b1, 8'hA5, 4'b0000, 1'b1);
    req = 4'b0000;
    step();
    chk_all("drop2", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b1);
    step();
    chk_all("idle2", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);

    // Abort: owner 1 drops its request in its second grant cycle; 3 is pending.
    req = 4'b0010;
    step();
    chk_all("ab.g1", 4'b0010, 1'b1, 8'h21, 4'b0000, 1'b1);
    req = 4'b1010;
    step();
    chk_all("ab.g2", 4'b0010, 1'b1, 8'h21, 4'b0000, 1'b1);
    req = 4'b1000;
    step();
    chk_all("ab.rel", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b1);
    step();
    chk_all("ab.next", 4'b1000, 1'b1, 8'h33, 4'b0000, 1'b1);
    chk("ab.owner", 32'(owner), 32'd3);

    // Reset in owner 3's second grant cycle; afterwards requester 0 wins first.
    req  = 4'b1001;
    d[0] = 8'h11;
    step();
    chk_all("rs.g2", 4'b1000, 1'b1, 8'h33, 4'b0000, 1'b1);
    rst = 1'b1;
    step();
    chk_all("rs.mid", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
    chk("rs.owner", 32'(owner), 32'd0);
    rst = 1'b0;
    step();
    chk_all("rs.g1", 4'b0001, 1'b1, 8'h11, 4'b0000, 1'b1);

    // Data tracking: a change in the first grant cycle shows up one cycle later.
    d[0] = 8'h22;
    step();
    chk_all("dt.g2", 4'b0001, 1'b1, 8'h22, 4'b0000, 1'b1);
    step();
    chk_all("dt.g3", 4'b0001, 1'b1, 8'h22, 4'b0000, 1'b1);
    step();
    chk_all("dt.rel", 4'b0000, 1'b0, 8'h00, 4'b0001, 1'b1);
    req = 4'b0000;
    step();
    chk_all("dt.idle", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/latch_rr_arbiter.md
Name: latch_rr_arbiter

Overview:
- Round-robin controller that shares one transparent-latch datapath (enable + data) among NREQ requesters.
- Grants one requester at a time and holds the latch open for HOLD cycles while forwarding that requester's data.
- Closes the latch (output forced to zero) for GAP cycles between owners, then re-arbitrates.
- Sits between requester clients and the latch stage, replacing the simple reset-driven enable generator.

Parameters:
- NREQ, 4, number of requesters (>=2).
- WIDTH, 32, data width per requester.
- HOLD, 4, cycles lat_en stays high per grant (>=1).
- GAP, 1, cycles lat_en stays low between grants (>=1).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  request per requester; level, held until done or abandoned.
- data_in  input  NREQ*WIDTH  packed data, requester i at bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot current owner, zero when no owner.
- owner  output  $clog2(NREQ)  index of current/last owner.
- lat_en  output  1  latch enable.
- lat_data  output  WIDTH  latch data; zero whenever lat_en=0.
- done  output  NREQ  one-cycle pulse to owner on completing a full HOLD window.
- busy  output  1  high in GRANT or RELEASE.

Behaviour:
- All outputs registered. Synchronous reset on rst: all outputs 0, state=IDLE, counters 0, rr pointer ptr=NREQ-1, so req[0] has first priority.
- States: IDLE, GRANT, RELEASE.
- Arbitration: selects the first asserted req scanning (ptr+1) mod NREQ upward with wrap. It runs in IDLE, and in the final RELEASE cycle.
- On a win:
  - next cycle state=GRANT, gnt=onehot(win), owner=win, lat_en=1, lat_data=data_in[win] sampled that cycle.
  - ptr<=win; hold counter loaded HOLD-1.
- GRANT:
  - Each cycle lat_data<=data_in[owner]; data changes appear one cycle later.
  - Counter decrements each cycle.
  - When counter==0 and req[owner] still high: done[owner] pulses the following cycle. In that same cycle gnt=0, lat_en=0, lat_data=0, state=RELEASE, gap counter=GAP-1.
  - lat_en is high exactly HOLD consecutive cycles.
- Abort: if req[owner]=0 in any GRANT cycle, the next cycle enters RELEASE exactly as above but with no done pulse.
- RELEASE:
  - lat_en=0, lat_data=0, gnt=0, busy=1 for GAP cycles.
  - On the last cycle, arbitrate. Winner → GRANT next cycle (lat_en low exactly GAP cycles). No requests → IDLE.
- IDLE: busy=0; owner retains last value.
- A requester that completed may re-request immediately; round-robin ensures every other pending requester is served first.
- Requests arriving during GRANT/RELEASE wait; no preemption.
- gnt is always one-hot or zero; lat_en==|gnt invariant.
- rst mid-operation wins over all: outputs zero next cycle, no done pulse, ptr restored.

Test Plan:
(NREQ=4, WIDTH=8, HOLD=3, GAP=1)
- Reset: hold rst 3 cycles with all req=1 → gnt, lat_en, lat_data, done, busy all 0. First grant after release goes to req[0].
- Single request: req[2]=1 with data 0xA5 at cycle 0 → lat_en=1 and lat_data=0xA5 in cycles 1–3, gnt=4'b0100. Cycle 4: lat_en=0, done[2]=1, lat_data=0x00. Cycle 5: new grant if req[2] still high.
- All four requesting continuously → owners 0,1,2,3,0,… Each window is 3 high cycles, separated by exactly 1 low cycle; done pulses in the same order.
- Abort: req[1] owner drops req in its 2nd GRANT cycle → next cycle lat_en=0, lat_data=0, done[1] stays 0. Pending req[3] is granted after 1 gap cycle.
- Data tracking: during grant to req[0], data_in[0] goes 0x11→0x22 at the grant's 1st cycle → lat_data=0x22 in the 2nd cycle.
- Reset mid-grant: rst asserted in the 2nd GRANT cycle of owner 3 → all outputs 0 next cycle. After release with req[0] and req[3] high, req[0] is granted first.
